// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : opcode/funct/ALU codes, FSM states and control decode tables
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // Control word asserted while sitting in state s; anything unlisted stays 0.
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_e next_state(input state_e s, input logic [5:0] op,
                                        input logic trap);
    state_e n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_EXECUTE;
          OP_BEQ:       n = S_BRANCH;
          OP_ADDI:      n = S_ADDIEX;
          OP_J:         n = S_JUMP;
          default:      n = trap ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:  n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   n = S_MEMWB;
      S_EXECUTE: n = S_ALUWB;
      S_ADDIEX:  n = S_ADDIWB;
      S_HALT:    n = S_HALT;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_aludec.sv
// ============================================================================
// aludec   : combinational ALU decoder (aluop, funct -> alucontrol)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller : Moore FSM sequencing the multicycle MIPS datapath
// Revision              : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import mips_pkg::*;
#(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q,  ctrl_d;
  logic   illegal_q;

  always_comb begin
    state_d = next_state(state_q, op, TRAP_ILLEGAL);
    ctrl_d  = state_ctrl(state_d);
  end

  // Control word is registered alongside the state so outputs are glitch-free
  // Moore values; reset forces both back to FETCH, cancelling any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= state_ctrl(S_FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_q | (state_d == S_HALT);
    end
  end

  aludec u_aludec (
    .aluop      (ctrl_q.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  assign pcen     = ctrl_q.pcwrite | (ctrl_q.branch & zero);
  assign memwrite = ctrl_q.memwrite;
  assign irwrite  = ctrl_q.irwrite;
  assign regwrite = ctrl_q.regwrite;
  assign iord     = ctrl_q.iord;
  assign memtoreg = ctrl_q.memtoreg;
  assign regdst   = ctrl_q.regdst;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle tables from a
// behavioural reference compared each cycle against all controller outputs.
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
  );

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int ref_len(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  // Expected output vector for cycle k of instruction o (k=0 is the fetch cycle).
  // Layout: pcen memwrite irwrite regwrite iord memtoreg regdst alusrca
  //         alusrcb[2] pcsrc[2] alucontrol[3] illegal
  function automatic logic [15:0] ref_vec(input logic [5:0] o, input logic [5:0] f,
                                          input int k, input logic z);
    logic pe = 0, mw = 0, irw = 0, rw = 0, io = 0, m2r = 0, rd = 0, asa = 0, ill = 0;
    logic [1:0] asb = 2'b00, psrc = 2'b00;
    logic [2:0] alu = 3'b010;
    if (k == 0) begin
      irw = 1; pe = 1; asb = 2'b01;
    end else if (k == 1) begin
      asb = 2'b11;
    end else begin
      case (o)
        6'b100011, 6'b101011: begin
          if (k == 2) begin asa = 1; asb = 2'b10; end
          if (k == 3) begin io = 1; mw = (o == 6'b101011); end
          if (k == 4) begin m2r = 1; rw = 1; end
        end
        6'b000000: begin
          if (k == 2) begin asa = 1; alu = ref_alu(f); end
          if (k == 3) begin rd = 1; rw = 1; end
        end
        6'b000100: begin
          asa = 1; alu = 3'b110; psrc = 2'b01; pe = z;
        end
        6'b001000: begin
          if (k == 2) begin asa = 1; asb = 2'b10; end
          if (k == 3) rw = 1;
        end
        6'b000010: begin
          psrc = 2'b10; pe = 1;
        end
        default: ill = 1;
      endcase
    end
    return {pe, mw, irw, rw, io, m2r, rd, asa, asb, psrc, alu, ill};
  endfunction

  function automatic logic [15:0] obs();
    return {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
            alusrcb, pcsrc, alucontrol, illegal};
  endfunction

  task automatic test_reset();
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (obs() !== ref_vec(6'b0, 6'b0, 0, zero)) begin
      bad++; $display("FAIL reset_held: got %b want %b", obs(), ref_vec(6'b0, 6'b0, 0, zero));
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs() !== 16'b1010_0000_0100_0100 || alucontrol !== 3'b010 || illegal !== 1'b0) begin
      bad++; $display("FAIL reset_release: got %b want %b", obs(), 16'b1010_0000_0100_0100);
    end
  endtask

  task automatic test_lw_sw();
    logic [5:0] ops [2] = '{6'b100011, 6'b101011};
    for (int i = 0; i < 2; i++) begin
      op = ops[i]; funct = 6'($urandom);
      for (int k = 0; k < ref_len(op); k++) begin
        zero = 1'($urandom_range(0, 1)); #1;
        total++;
        if (obs() !== ref_vec(op, funct, k, zero)) begin
          bad++; $display("FAIL mem op=%b cyc=%0d: got %b want %b", op, k, obs(), ref_vec(op, funct, k, zero));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fs [3] = '{6'b100010, 6'b101010, 6'b111001};
    op = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      funct = fs[i];
      for (int k = 0; k < 4; k++) begin
        zero = 1'($urandom_range(0, 1)); #1;
        total++;
        if (obs() !== ref_vec(op, funct, k, zero)) begin
          bad++; $display("FAIL rtype funct=%b cyc=%0d: got %b want %b", funct, k, obs(), ref_vec(op, funct, k, zero));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_beq();
    op = 6'b000100; funct = 6'($urandom);
    for (int z = 1; z >= 0; z--) begin
      for (int k = 0; k < 3; k++) begin
        zero = (k == 2) ? 1'(z) : 1'($urandom_range(0, 1)); #1;
        total++;
        if (obs() !== ref_vec(op, funct, k, zero)) begin
          bad++; $display("FAIL beq zero=%0d cyc=%0d: got %b want %b", zero, k, obs(), ref_vec(op, funct, k, zero));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fs  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 5)];
      funct = ($urandom_range(0, 3) != 0) ? fs[$urandom_range(0, 4)] : 6'($urandom);
      for (int k = 0; k < ref_len(op); k++) begin
        zero = 1'($urandom_range(0, 1)); #1;
        total++;
        if (obs() !== ref_vec(op, funct, k, zero)) begin
          bad++; $display("FAIL random n=%0d op=%b cyc=%0d: got %b want %b", n, op, k, obs(), ref_vec(op, funct, k, zero));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b101011; funct = 6'($urandom);
    for (int k = 0; k < 4; k++) begin
      zero = 1'($urandom_range(0, 1)); #1;
      total++;
      if (obs() !== ref_vec(op, funct, k, zero)) begin
        bad++; $display("FAIL sw_pre_reset cyc=%0d: got %b want %b", k, obs(), ref_vec(op, funct, k, zero));
      end
      if (k < 3) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    total++;
    if (memwrite !== 1'b0 || obs() !== ref_vec(op, funct, 0, zero)) begin
      bad++; $display("FAIL reset_mid_sw: got %b want %b", obs(), ref_vec(op, funct, 0, zero));
    end
    reset = 1'b0;
  endtask

  task automatic test_illegal();
    op = 6'b111111; funct = 6'($urandom);
    for (int k = 0; k < 7; k++) begin
      zero = 1'($urandom_range(0, 1)); #1;
      total++;
      if (obs() !== ref_vec(op, funct, k, zero)) begin
        bad++; $display("FAIL illegal cyc=%0d: got %b want %b", k, obs(), ref_vec(op, funct, k, zero));
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    total++;
    if (illegal !== 1'b0 || obs() !== ref_vec(6'b0, funct, 0, zero)) begin
      bad++; $display("FAIL illegal_clear: got %b want %b", obs(), ref_vec(6'b0, funct, 0, zero));
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw_sw();
    test_rtype();
    test_beq();
    test_random();
    test_reset_mid();
    test_lw_sw();
    test_illegal();
    test_beq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
